mux_port_arbiter: RTL and testbench

// - Round-robin arbiter sharing one 32-bit datapath resource (e.g. memory/bus port) among 4 requesters.
// - Drives the 2-bit control of the mux4_1 instances that steer each requester's address/data onto the shared port.
// - Holds a grant until the resource signals completion.
// - Sits between the requesting units and the shared-port mux.

---
 rtl/mux_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mux_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_port_arbiter.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : mux_port_arbiter
// Purpose  : Round-robin arbiter sharing one 32-bit datapath resource among
//            four requesters. Drives the 2-bit select of the mux4_1 steering
//            logic and holds each grant until the resource reports done.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
// Ports
//   Clk      in   1  rising-edge clock
//   Reset_n  in   1  synchronous, active-low reset
//   req      in   4  request per requester (bit i = requester i)
//   done     in   1  shared resource finished current transaction
//   grant    out  4  one-hot grant, registered
//   sel      out  2  index of granted requester, registered
//   start    out  1  pulse in the first BUSY cycle of each grant
//   busy     out  1  high while a grant is held
//   timeout  out  1  pulse on forced release (ARB_TIMEOUT_EN only)
// Configuration
//   ARB_TIMEOUT_EN : when defined, a grant held MAX_HOLD cycles without done
//                    is forcibly released. When undefined, timeout is tied 0
//                    and BUSY waits indefinitely for done.
//-----------------------------------------------------------------------------
module mux_port_arbiter #(
   parameter int MAX_HOLD  = 16,
   parameter int TIMEOUT_W = 5
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic       start,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [1:0] ptr;
   logic [1:0] ptr_nxt;
   logic [3:0] grant_nxt;
   logic [1:0] sel_nxt;
   logic       start_nxt;
   logic       busy_nxt;
   logic [1:0] winner;
   logic       force_rel;

   // Priority scan starting at ptr. Iterating from the farthest offset down
   // to offset 0 lets the nearest set request overwrite the others.
   always_comb begin
      logic [1:0] idx;
      idx    = 2'd0;
      winner = ptr;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (req[idx]) begin
            winner = idx;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] hold;
   logic [TIMEOUT_W-1:0] hold_nxt;
   logic                 timeout_nxt;

   // A coincident done takes priority, so force_rel requires done low.
   assign force_rel = (state == BUSY) && !done &&
                      (hold == TIMEOUT_W'(MAX_HOLD - 1));

   always_comb begin
      hold_nxt    = hold;
      timeout_nxt = 1'b0;
      if (state == IDLE) begin
         if (|req) begin
            hold_nxt = '0;
         end
      end else if (!done) begin
         hold_nxt    = hold + TIMEOUT_W'(1);
         timeout_nxt = force_rel;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         hold    <= '0;
         timeout <= 1'b0;
      end else begin
         hold    <= hold_nxt;
         timeout <= timeout_nxt;
      end
   end
`else
   // Hold limit parameters only matter when the timeout feature is built.
   logic unused_cfg;
   assign unused_cfg = (MAX_HOLD > 0) ^ (TIMEOUT_W > 0);
   assign force_rel  = 1'b0;
   assign timeout    = 1'b0;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      grant_nxt = grant;
      sel_nxt   = sel;
      start_nxt = 1'b0;
      busy_nxt  = busy;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = BUSY;
               grant_nxt = 4'b0001 << winner;
               sel_nxt   = winner;
               busy_nxt  = 1'b1;
               start_nxt = 1'b1;
            end
         end
         BUSY: begin
            // req is deliberately ignored here; sel keeps the last winner.
            if (done || force_rel) begin
               state_nxt = IDLE;
               grant_nxt = 4'b0000;
               busy_nxt  = 1'b0;
               ptr_nxt   = sel + 2'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = 4'b0000;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state <= IDLE;
         ptr   <= 2'd0;
         grant <= 4'b0000;
         sel   <= 2'd0;
         start <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         grant <= grant_nxt;
         sel   <= sel_nxt;
         start <= start_nxt;
         busy  <= busy_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mux_port_arbiter.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : tb_mux_port_arbiter
// Purpose  : Self-checking bench for mux_port_arbiter. Expected grants are
//            queued as requests are driven and popped when start pulses.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
module tb_mux_port_arbiter;

   logic       Clk;
   logic       Reset_n;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       start;
   logic       busy;
   logic       timeout;

   int checks   = 0;
   int failures = 0;

   // {sel, grant} expected for each upcoming grant
   logic [5:0] exp_q[$];

   mux_port_arbiter #(
      .MAX_HOLD  (16),
      .TIMEOUT_W (5)
   ) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .req     (req),
      .done    (done),
      .grant   (grant),
      .sel     (sel),
      .start   (start),
      .busy    (busy),
      .timeout (timeout)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_grant"}, 32'(grant), 32'h0);
      chk({tag, "_busy"},  32'(busy),  32'h0);
      chk({tag, "_start"}, 32'(start), 32'h0);
   endtask

   task automatic expect_grant(input int idx);
      logic [3:0] g;
      g = 4'b0001 << idx;
      exp_q.push_back({2'(idx), g});
   endtask

   // Scoreboard and invariant monitor, sampled on the falling edge.
   always @(negedge Clk) begin
      logic [5:0] e;
      if (start) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_start", 32'(grant), 32'h0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_grant", 32'(grant), 32'(e[3:0]));
            chk("sb_sel",   32'(sel),   32'(e[5:4]));
         end
      end
      chk("inv_onehot", 32'((grant & (grant - 4'd1)) == 4'd0), 32'h1);
      if (busy) begin
         chk("inv_grant_sel", 32'(grant[sel]), 32'h1);
      end
`ifndef ARB_TIMEOUT_EN
      chk("inv_timeout_zero", 32'(timeout), 32'h0);
`endif
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset_n = 1'b0;
      req     = 4'b1111;
      done    = 1'b0;

      // Reset held with all requests asserted.
      tick();
      chk_idle("rst1");
      chk("rst1_sel", 32'(sel), 32'h0);
      tick();
      chk_idle("rst2");
      chk("rst2_sel", 32'(sel), 32'h0);

      Reset_n = 1'b1;
      req     = 4'b0000;
      tick();
      chk_idle("idle_noreq");

      // Single request from requester 2.
      req = 4'b0100;
      expect_grant(2);
      tick();
      chk("single_grant", 32'(grant), 32'h4);
      chk("single_sel",   32'(sel),   32'h2);
      chk("single_start", 32'(start), 32'h1);
      chk("single_busy",  32'(busy),  32'h1);
      req = 4'b0000;
      tick();
      chk("single_start_off", 32'(start), 32'h0);
      chk("single_hold",      32'(grant), 32'h4);
      tick();
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_idle("single_release");
      chk("single_sel_kept", 32'(sel), 32'h2);

      // Pointer now 3: requester 3 wins, then reset mid-BUSY.
      req = 4'b1000;
      expect_grant(3);
      tick();
      chk("midrst_grant", 32'(grant), 32'h8);
      Reset_n = 1'b0;
      tick();
      chk_idle("midrst");
      chk("midrst_sel", 32'(sel), 32'h0);
      Reset_n = 1'b1;

      // Round robin from pointer 0 with all requests held.
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         expect_grant(i % 4);
         tick();
         chk("rr_grant", 32'(grant), 32'(4'b0001 << (i % 4)));
         chk("rr_start", 32'(start), 32'h1);
         tick();
         chk("rr_start_off", 32'(start), 32'h0);
         chk("rr_hold", 32'(grant), 32'(4'b0001 << (i % 4)));
         done = 1'b1;
         tick();
         done = 1'b0;
         chk_idle("rr_gap");
      end
      req = 4'b0000;
      tick();

      // Pointer is 1: grant requester 1 with done coincident with start.
      req = 4'b0010;
      expect_grant(1);
      tick();
      chk("coinc_grant", 32'(grant), 32'h2);
      req  = 4'b0000;
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_idle("coinc_release");

      // Pointer skip: only requester 0 asks, wraps past 2 and 3.
      req = 4'b0001;
      expect_grant(0);
      tick();
      chk("skip_grant", 32'(grant), 32'h1);
      chk("skip_sel",   32'(sel),   32'h0);
      req = 4'b0000;
      tick();
      tick();
      chk("drop_hold_grant", 32'(grant), 32'h1);
      chk("drop_hold_busy",  32'(busy),  32'h1);
      req = 4'b1110;
      tick();
      chk("busy_ignore_req", 32'(grant), 32'h1);
      req  = 4'b0000;
      done = 1'b1;
      tick();
      chk_idle("drop_release");
      // done while idle is ignored
      tick();
      done = 1'b0;
      chk_idle("done_idle");

      // Pointer is 1; requester 2 alone.
      req = 4'b0100;
      expect_grant(2);
      tick();
      chk("last_grant", 32'(grant), 32'h4);
      req  = 4'b0000;
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_idle("last_release");

`ifdef ARB_TIMEOUT_EN
      // Pointer is 3; done never asserted -> forced release after 16 cycles.
      req = 4'b1111;
      expect_grant(3);
      tick();
      chk("to_grant", 32'(grant), 32'h8);
      for (int c = 0; c < 15; c++) begin
         tick();
         chk("to_busy", 32'(busy), 32'h1);
         chk("to_no_pulse", 32'(timeout), 32'h0);
      end
      expect_grant(0);
      tick();
      chk_idle("to_release");
      chk("to_pulse", 32'(timeout), 32'h1);
      tick();
      chk("to_next_grant", 32'(grant), 32'h1);
      chk("to_pulse_off",  32'(timeout), 32'h0);
      req  = 4'b0000;
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_idle("to_final");
`endif

      tick();
      chk("sb_queue_empty", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
